// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational add/sub/inc/dec unit
// between two valid/ready requesters; results returned per owner.
module alu_arbiter #(
  parameter int WIDTH   = 4,
  parameter bit RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_sum,
  output logic             rsp0_cout,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_sum,
  output logic             rsp1_cout,
  output logic             alu_c1,
  output logic             alu_c2,
  output logic [WIDTH-1:0] alu_ia,
  output logic [WIDTH-1:0] alu_ib,
  input  logic [WIDTH-1:0] alu_sum,
  input  logic             alu_cout,
  output logic             busy,
  output logic             owner
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             owner_q;
  logic             rr_ptr;
  logic             gnt1;
  logic             take;
  logic             own_ready;

  // Requester 1 wins when alone or when the pointer favours it.
  assign gnt1 = req1_valid & (~req0_valid | rr_ptr);
  assign take = (state == IDLE) & (req0_valid | req1_valid);
  assign own_ready = owner_q ? rsp1_ready : rsp0_ready;

  assign req0_ready = (state == IDLE) & req0_valid & ~gnt1;
  assign req1_ready = (state == IDLE) & gnt1;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (take) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    if (own_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      owner_q <= 1'b0;
      rr_ptr  <= RR_INIT;
    end else begin
      state <= state_nx;
      if (take) begin
        op_q    <= gnt1 ? req1_op : req0_op;
        a_q     <= gnt1 ? req1_a : req0_a;
        b_q     <= gnt1 ? req1_b : req0_b;
        owner_q <= gnt1;
        rr_ptr  <= ~gnt1;
      end
      if (state == ISSUE) begin
        sum_q  <= alu_sum;
        cout_q <= alu_cout;
      end
    end
  end

  assign alu_c1 = op_q[1];
  assign alu_c2 = op_q[0];
  assign alu_ia = a_q;
  assign alu_ib = b_q;

  assign rsp0_valid = (state == RESP) & ~owner_q;
  assign rsp1_valid = (state == RESP) & owner_q;
  assign rsp0_sum   = sum_q;
  assign rsp1_sum   = sum_q;
  assign rsp0_cout  = cout_q;
  assign rsp1_cout  = cout_q;

  assign busy  = (state != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural shared unit, per-requester
// scoreboards, and scenario tasks with inline checks.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_op = '0, req1_op = '0;
  logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       rsp0_valid, rsp1_valid;
  logic       rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [3:0] rsp0_sum, rsp1_sum;
  logic       rsp0_cout, rsp1_cout;
  logic       alu_c1, alu_c2;
  logic [3:0] alu_ia, alu_ib, alu_sum;
  logic       alu_cout;
  logic       busy, owner;

  int errors = 0;
  int checks = 0;
  logic [4:0] q0[$];
  logic [4:0] q1[$];

  always #5 clk = ~clk;

  // Shared unit: Add a+b, Sub ~a+b, Inc b+1, Dec b+F.
  function automatic logic [4:0] ref_alu(input logic [1:0] op,
                                         input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] r;
    case (op)
      2'b00:   r = {1'b0, a} + {1'b0, b};
      2'b01:   r = {1'b0, ~a} + {1'b0, b};
      2'b10:   r = {1'b0, b} + 5'd1;
      default: r = {1'b0, b} + 5'd15;
    endcase
    return r;
  endfunction

  assign {alu_cout, alu_sum} = ref_alu({alu_c1, alu_c2}, alu_ia, alu_ib);

  alu_arbiter #(.WIDTH(4), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_sum(rsp0_sum), .rsp0_cout(rsp0_cout),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_sum(rsp1_sum), .rsp1_cout(rsp1_cout),
    .alu_c1(alu_c1), .alu_c2(alu_c2),
    .alu_ia(alu_ia), .alu_ib(alu_ib),
    .alu_sum(alu_sum), .alu_cout(alu_cout),
    .busy(busy), .owner(owner)
  );

  // Scoreboard: push on request handshake, pop on response handshake.
  always @(negedge clk) begin
    #3;
    if (rst_n) begin
      if (req0_valid && req0_ready)
        q0.push_back(ref_alu(req0_op, req0_a, req0_b));
      if (req1_valid && req1_ready)
        q1.push_back(ref_alu(req1_op, req1_a, req1_b));
      if (rsp0_valid && rsp0_ready) begin
        logic [4:0] e0;
        checks++;
        if (q0.size() == 0) begin
          errors++;
          $display("FAIL sb_rsp0 unexpected got=%h", {rsp0_cout, rsp0_sum});
        end else begin
          e0 = q0.pop_front();
          if ({rsp0_cout, rsp0_sum} !== e0) begin
            errors++;
            $display("FAIL sb_rsp0 got=%h exp=%h", {rsp0_cout, rsp0_sum}, e0);
          end
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        logic [4:0] e1;
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL sb_rsp1 unexpected got=%h", {rsp1_cout, rsp1_sum});
        end else begin
          e1 = q1.pop_front();
          if ({rsp1_cout, rsp1_sum} !== e1) begin
            errors++;
            $display("FAIL sb_rsp1 got=%h exp=%h", {rsp1_cout, rsp1_sum}, e1);
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    step();
    step();
    q0.delete();
    q1.delete();
    rst_n = 1'b1;
    step();
  endtask

  // Present a request and wait (bounded) until it is accepted; returns
  // at the first cycle after the handshake edge.
  task automatic issue(input bit n, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    bit got = 0;
    if (n) begin
      req1_valid = 1; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_op = op; req0_a = a; req0_b = b;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      got = n ? req1_ready : req0_ready;
      step();
    end
    if (n) req1_valid = 0;
    else req0_valid = 0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout req%0d got=0 exp=1", n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++;
    if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000",
               {req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner});
    end
    checks++;
    if ({alu_c1, alu_c2, alu_ia, alu_ib} !== 10'h0) begin
      errors++;
      $display("FAIL reset_alu got=%h exp=0", {alu_c1, alu_c2, alu_ia, alu_ib});
    end
    do_reset();
  endtask

  task automatic test_single_add();
    req0_valid = 1; req0_op = 2'b00; req0_a = 4'h3; req0_b = 4'h4;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_ready got=%b exp=1", req0_ready);
    end
    step();
    req0_valid = 0;
    checks++;
    if ({req0_ready, busy, rsp0_valid, alu_ia, alu_ib, alu_c1, alu_c2} !== {3'b010, 8'h34, 2'b00}) begin
      errors++;
      $display("FAIL add_issue got=%h exp=%h",
               {req0_ready, busy, rsp0_valid, alu_ia, alu_ib, alu_c1, alu_c2},
               {3'b010, 8'h34, 2'b00});
    end
    step();
    checks++;
    if ({rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum} !== {3'b100, 4'h7}) begin
      errors++;
      $display("FAIL add_rsp got=%h exp=%h",
               {rsp0_valid, rsp1_valid, rsp0_cout, rsp0_sum}, {3'b100, 4'h7});
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL add_idle busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_carry_dec();
    logic [4:0] exp_tab [2];
    logic [4:0] got;
    exp_tab[0] = 5'h0F;
    exp_tab[1] = 5'h10;
    for (int k = 0; k < 2; k++) begin
      bit seen = 0;
      if (k == 0) issue(1'b1, 2'b11, 4'h0, 4'h0);
      else issue(1'b1, 2'b00, 4'hF, 4'h1);
      got = '0;
      for (int i = 0; i < 10 && !seen; i++) begin
        if (rsp1_valid) begin
          seen = 1;
          got = {rsp1_cout, rsp1_sum};
        end
        step();
      end
      checks++;
      if (!seen || got !== exp_tab[k]) begin
        errors++;
        $display("FAIL carry_dec_%0d got=%h seen=%0d exp=%h", k, got, seen, exp_tab[k]);
      end
    end
  endtask

  task automatic test_contention();
    do_reset();
    req0_valid = 1; req0_op = 2'b10; req0_a = 4'h0; req0_b = 4'h2;
    req1_valid = 1; req1_op = 2'b01; req1_a = 4'h1; req1_b = 4'h5;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL cont_grant0 got=%b exp=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 0;
    step();
    checks++;
    if ({rsp0_valid, rsp0_cout, rsp0_sum} !== {2'b10, 4'h3}) begin
      errors++;
      $display("FAIL cont_rsp0 got=%h exp=%h", {rsp0_valid, rsp0_cout, rsp0_sum}, {2'b10, 4'h3});
    end
    step();
    checks++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL cont_grant1 got=%b exp=01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 0;
    checks++;
    if (owner !== 1'b1) begin
      errors++;
      $display("FAIL cont_owner got=%b exp=1", owner);
    end
    step();
    checks++;
    if ({rsp1_valid, rsp0_valid, rsp1_cout, rsp1_sum} !== {3'b101, 4'h3}) begin
      errors++;
      $display("FAIL cont_rsp1 got=%h exp=%h",
               {rsp1_valid, rsp0_valid, rsp1_cout, rsp1_sum}, {3'b101, 4'h3});
    end
    step();
  endtask

  task automatic test_backpressure();
    bit bad = 0;
    rsp0_ready = 0;
    rsp1_ready = 1;
    issue(1'b0, 2'b00, 4'h5, 4'h6);
    req1_valid = 1; req1_op = 2'b10; req1_a = 4'h0; req1_b = 4'h7;
    step();
    for (int i = 0; i < 5; i++) begin
      if (!(rsp0_valid === 1'b1 && rsp0_sum === 4'hB && rsp0_cout === 1'b0 &&
            busy === 1'b1 && req0_ready === 1'b0 && req1_ready === 1'b0 &&
            rsp1_valid === 1'b0 && owner === 1'b0))
        bad = 1;
      step();
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL backpressure_hold got=%b%h%b exp=1b10", rsp0_valid, rsp0_sum, busy);
    end
    rsp0_ready = 1;
    step();
    checks++;
    if ({busy, req1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release got=%b exp=01", {busy, req1_ready});
    end
    step();
    req1_valid = 0;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    int g[$];
    do_reset();
    req0_valid = 1; req0_op = 2'b00; req0_a = 4'h1; req0_b = 4'h2;
    req1_valid = 1; req1_op = 2'b00; req1_a = 4'h4; req1_b = 4'h4;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (req0_ready) g.push_back(0);
      if (req1_ready) g.push_back(1);
      step();
    end
    req0_valid = 0;
    req1_valid = 0;
    checks++;
    if (g.size() < 4) begin
      errors++;
      $display("FAIL rr_count got=%0d exp=4", g.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (g[i] !== (i % 2)) begin
          errors++;
          $display("FAIL rr_order%0d got=%0d exp=%0d", i, g[i], i % 2);
        end
      end
    end
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    issue(1'b0, 2'b00, 4'h9, 4'h9);
    rst_n = 0;
    #1;
    checks++;
    if ({busy, owner, rsp0_valid, rsp1_valid, alu_c1, alu_c2, alu_ia, alu_ib} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_out got=%h exp=0",
               {busy, owner, rsp0_valid, rsp1_valid, alu_c1, alu_c2, alu_ia, alu_ib});
    end
    q0.delete();
    q1.delete();
    step();
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      if (rsp0_valid || rsp1_valid || busy) seen = 1;
      step();
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_norsp got=1 exp=0");
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_carry_dec();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    step();
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d/%0d exp=0/0", q0.size(), q1.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 4-bit add/sub/inc/dec unit between two independent requesters.
- Each requester submits operations over a valid/ready request channel and receives results over a valid/ready response channel.
- The block arbitrates round-robin, registers operands, drives the shared unit's op-select and operand inputs, captures sum/carry, and returns the result to the owning requester.
- Sits between the lab's control logic (two clients) and the ALU instance.

Parameters:
- WIDTH, 4: operand/sum width; must match the shared unit's operand width.
- RR_INIT, 0: requester favoured by the round-robin pointer after reset (0 or 1).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  00 Add, 01 Sub, 10 Inc, 11 Dec
- req0_a  in  WIDTH  operand A
- req0_b  in  WIDTH  operand B
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- rsp0_valid  out  1  result for requester 0 available
- rsp0_ready  in  1  requester 0 consumes result
- rsp0_sum  out  WIDTH  result value
- rsp0_cout  out  1  result carry
- rsp1_valid, rsp1_ready, rsp1_sum, rsp1_cout: same as requester 0, for requester 1
- alu_c1  out  1  op select MSB to shared unit (= latched op[1])
- alu_c2  out  1  op select LSB to shared unit (= latched op[0])
- alu_ia  out  WIDTH  operand A to shared unit
- alu_ib  out  WIDTH  operand B to shared unit
- alu_sum  in  WIDTH  shared unit sum (combinational from alu_* outputs)
- alu_cout  in  1  shared unit carry
- busy  out  1  high in any state other than IDLE
- owner  out  1  index of requester currently holding the unit

Behaviour:
- States: IDLE, ISSUE, RESP. Reset -> IDLE.
- Reset values: operand/op regs 0 (so alu_c1/c2/ia/ib = 0), result regs 0, owner 0, rr_ptr = RR_INIT, all valid/ready outputs 0, busy 0. Reset mid-operation abandons the operation; no response is produced.
- IDLE arbitration (combinational):
  - Only one reqN_valid -> grant N.
  - Both valid -> grant rr_ptr.
  - reqN_ready = (state==IDLE) && granted N; never high in ISSUE or RESP.
- Handshake (valid && ready at edge T):
  - Latch op, a, b and owner = N.
  - rr_ptr <= ~N.
  - Next state ISSUE.
- ISSUE (cycle T+1):
  - alu_* driven from latched regs.
  - At the edge, capture {alu_cout, alu_sum} into result regs.
  - Next state RESP.
- RESP (from T+2):
  - rsp[owner]_valid = 1; the other rsp_valid = 0.
  - rsp_sum/rsp_cout hold the captured values, stable until accepted.
  - rsp[owner]_ready high -> IDLE at the next edge.
  - rsp_ready from the non-owner is ignored.
- Latency: request handshake to rsp_valid = 2 cycles. Minimum issue interval 3 cycles per operation.
- rspN_sum/cout outputs mirror the result regs whenever valid; their value while valid=0 is undefined to the client.
- alu_* outputs hold the last latched operands outside ISSUE; no glitch-free requirement.
- Arithmetic is performed entirely by the shared unit; the block never alters operands. op passes straight to {alu_c1, alu_c2}.
- Request held while the other requester is served: reqN_valid may stay high; it must not be lost and is granted in the next IDLE.
- Requester deasserting valid before grant: no effect, no response.
- Fairness: with both valid continuously, grants alternate 0,1,0,1… starting at RR_INIT.

Test Plan:
- Single Add: reset, req0 op=00 a=4'h3 b=4'h4 -> req0_ready 1 cycle; rsp0_valid at T+2, sum=4'h7, cout=0; rsp1_valid stays 0.
- Carry/Dec: req1 op=11 b=4'h0 -> rsp1 sum=4'hF, cout=0. Then req1 op=00 a=4'hF b=4'h1 -> sum=4'h0, cout=1.
- Contention: both valid from reset (RR_INIT=0), req0 Inc b=2, req1 Sub a=1 b=5 -> grant order 0 then 1. rsp0 sum=3; rsp1 = ~1+5 -> sum=4'h3, cout=1.
- Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and sum stable, req ready low, busy high throughout; release -> IDLE next edge.
- Non-owner ready: rsp1_ready high while owner=0 -> no state change.
- Reset mid-op: rst_n low during ISSUE -> all outputs to reset values immediately; no rsp_valid after release.
